// File: rtl/fpga_status_led_ctrl.sv
// ---------------------------------------------------------------------------
// fpga_status_led_ctrl
//
// Board-status LED controller. Drives NUM_LEDS independently moded LED
// channels from a shared blink timebase. Each channel can also stretch
// short event strobes into visible pulses. Once the SoC reports an exit,
// a sticky pass/fail pattern replaces all channel modes.
//
// Ports
//   clk_i          : system clock
//   rst_i          : synchronous active-high reset
//   mode_i         : per-channel mode, channel k uses [2k+1:2k]
//                    (00 off, 01 on, 10 blink, 11 event-stretch)
//   half_period_i  : blink half-period in cycles (0 is treated as 1)
//   event_i        : per-channel event strobes, level-sampled every cycle
//   exit_valid_i   : SoC exit-valid
//   exit_value_i   : SoC exit value (0 = pass)
//   led_o          : registered LED drive, active-high
//   blink_phase_o  : current shared blink phase
//   exit_latched_o : high once an exit has been captured
// ---------------------------------------------------------------------------
module fpga_status_led_ctrl #(
   parameter int NUM_LEDS       = 4,
   parameter int CNT_WIDTH      = 27,
   parameter int STRETCH_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [2*NUM_LEDS-1:0] mode_i,
   input  logic [CNT_WIDTH-1:0]  half_period_i,
   input  logic [NUM_LEDS-1:0]   event_i,
   input  logic                  exit_valid_i,
   input  logic [31:0]           exit_value_i,
   output logic [NUM_LEDS-1:0]   led_o,
   output logic                  blink_phase_o,
   output logic                  exit_latched_o
);

   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

   // Shared blink timebase
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic [CNT_WIDTH-1:0] eff;
   logic                 phase_reg, phase_next;

   // Sticky exit capture
   logic                 exit_latched_reg, exit_latched_next;
   logic [31:0]          exit_code_reg, exit_code_next;

   // LED drive
   logic [NUM_LEDS-1:0]  chan_val;
   logic [NUM_LEDS-1:0]  phase_vec;
   logic [NUM_LEDS-1:0]  fail_slice;
   logic [NUM_LEDS-1:0]  led_reg, led_next;

   // -----------------------------------------------------------------------
   // Blink timebase. The ">=" compare means that when half_period_i drops
   // below the running count, the counter wraps on the next cycle instead
   // of running on to its overflow.
   // -----------------------------------------------------------------------
   always_comb begin
      eff        = (half_period_i == '0) ? CNT_WIDTH'(1) : half_period_i;
      cnt_next   = cnt_reg + CNT_WIDTH'(1);
      phase_next = phase_reg;
      if (cnt_reg >= eff - CNT_WIDTH'(1)) begin
         cnt_next   = '0;
         phase_next = ~phase_reg;
      end
   end

   // -----------------------------------------------------------------------
   // Per-channel stretch counter and mode mux
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
         logic [SW-1:0] stretch_reg, stretch_next;
         logic [1:0]    mode_k;

         assign mode_k = mode_i[2*gi +: 2];

         // A new event reloads the counter even when it is about to expire,
         // so back-to-back events never leave a dark gap. The counter runs
         // in every mode, so switching into stretch mode shows any time left.
         always_comb begin
            stretch_next = stretch_reg;
            if (event_i[gi]) begin
               stretch_next = STRETCH_LOAD;
            end else if (stretch_reg != '0) begin
               stretch_next = stretch_reg - SW'(1);
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               stretch_reg <= '0;
            end else begin
               stretch_reg <= stretch_next;
            end
         end

         // The counter loaded by the event edge drives the LED on the
         // following edges, giving exactly STRETCH_CYCLES lit cycles per
         // isolated event.
         assign chan_val[gi] = (mode_k == 2'b00) ? 1'b0 :
                               (mode_k == 2'b01) ? 1'b1 :
                               (mode_k == 2'b10) ? phase_reg :
                                                   (stretch_reg != '0);
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Exit capture and output override
   // -----------------------------------------------------------------------
   assign phase_vec  = {NUM_LEDS{phase_reg}};
   assign fail_slice = exit_code_reg[NUM_LEDS-1:0];

   always_comb begin
      exit_latched_next = exit_latched_reg;
      exit_code_next    = exit_code_reg;
      if (exit_valid_i && !exit_latched_reg) begin
         exit_latched_next = 1'b1;
         exit_code_next    = exit_value_i;
      end

      led_next = chan_val;
      if (exit_latched_reg) begin
         if (exit_code_reg == 32'd0) begin
            led_next = '1;
         end else if (fail_slice == '0) begin
            // The failure code has no bits in the visible slice. Blink
            // everything so that a failure never looks dark.
            led_next = phase_vec;
         end else begin
            led_next = fail_slice & phase_vec;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_reg          <= '0;
         phase_reg        <= 1'b0;
         exit_latched_reg <= 1'b0;
         exit_code_reg    <= '0;
         led_reg          <= '0;
      end else begin
         cnt_reg          <= cnt_next;
         phase_reg        <= phase_next;
         exit_latched_reg <= exit_latched_next;
         exit_code_reg    <= exit_code_next;
         led_reg          <= led_next;
      end
   end

   assign led_o          = led_reg;
   assign blink_phase_o  = phase_reg;
   assign exit_latched_o = exit_latched_reg;

endmodule
